// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch control block.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Memory request/response, decode handshake and redirect signals of the fetch unit.
interface fetch_if #(
  parameter int unsigned N = 32
);
  import fetch_pkg::*;

  logic             mem_req;
  logic [N-1:0]     mem_addr;
  logic             mem_ack;
  logic [N-1:0]     mem_rdata;
  logic             instr_valid;
  logic [N-1:0]     instr;
  logic [N-1:0]     instr_pc;
  logic             dec_ready;
  logic             branch_taken;
  logic [N-1:0]     branch_target;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_cnt,
    input  mem_ack, mem_rdata, dec_ready, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_cnt,
    output mem_ack, mem_rdata, dec_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with synchronous active-low reset and load enable.
module pc_reg #(
  parameter int unsigned    N           = 32,
  parameter logic [N-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Single-outstanding instruction fetch FSM with decode handshake and branch redirect.
module fetch_control
  import fetch_pkg::*;
#(
  parameter int unsigned  N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR)
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  fetch_state_t     state_q;
  logic [N-1:0]     pc;
  logic [N-1:0]     pc_next;
  logic             pc_load;
  logic [N-1:0]     instr_q;
  logic [N-1:0]     instr_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_req_q;
  logic             valid_q;

  // Redirect wins over a completing fetch; the low two target bits are dropped.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc;
    if (bus.branch_taken) begin
      pc_load = 1'b1;
      pc_next = bus.branch_target & ~N'(3);
    end else if (state_q == S_REQ && bus.mem_ack) begin
      pc_load = 1'b1;
      pc_next = pc + N'(PC_INC);
    end
  end

  pc_reg #(
    .N           (N),
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  // mem_req and instr_valid are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else if (bus.branch_taken) begin
      state_q   <= S_REQ;
      mem_req_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q   <= S_REQ;
          mem_req_q <= 1'b1;
          valid_q   <= 1'b0;
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            instr_q    <= bus.mem_rdata;
            instr_pc_q <= pc;
            state_q    <= S_HOLD;
            mem_req_q  <= 1'b0;
            valid_q    <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.dec_ready) begin
            cnt_q     <= cnt_q + 1'b1;
            state_q   <= S_REQ;
            mem_req_q <= 1'b1;
            valid_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule
